// File: rtl/param_stream_loader.sv
// Chunk-serial parameter loader: assembles NWORDS x WORD_W words from IN_W-bit chunks,
// checks an XOR checksum and a gap timeout, commits atomically, then pulses start_calc.
module param_stream_loader #(
  parameter int NWORDS  = 2,
  parameter int WORD_W  = 32,
  parameter int IN_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic                     core_busy,
  output logic                     in_ready,
  output logic [NWORDS*WORD_W-1:0] words,
  output logic                     start_calc,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int BPW   = WORD_W / IN_W;
  localparam int TOTAL = NWORDS * BPW;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DW    = NWORDS * WORD_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   tmo;
  logic [IN_W-1:0] acc;
  logic [DW-1:0]   shadow, words_q;
  logic            start_q, err_q;
  logic            sof_acc, data_acc, chk_good, chk_bad, tmo_inc, tmo_hit, fire;

  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (ena) state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sof_acc  = 1'b0;
    data_acc = 1'b0;
    chk_good = 1'b0;
    chk_bad  = 1'b0;
    tmo_inc  = 1'b0;
    tmo_hit  = 1'b0;
    fire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ena && in_valid && in_sof) begin
          sof_acc = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ena) begin
          if (in_valid) begin
            // sof takes priority, so a sof arriving at cnt==TOTAL restarts instead of checking
            if (in_sof) begin
              sof_acc = 1'b1;
            end else if (cnt < CW'(TOTAL)) begin
              data_acc = 1'b1;
            end else if (in_data == acc) begin
              chk_good = 1'b1;
              state_n  = S_ARM;
            end else begin
              chk_bad = 1'b1;
              state_n = S_IDLE;
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            tmo_hit = 1'b1;
            state_n = S_IDLE;
          end else begin
            tmo_inc = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (ena && !core_busy) begin
          fire    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_IDLE) || (state == S_LOAD);
    busy       = (state != S_IDLE);
    words      = words_q;
    start_calc = start_q & ena;
    frame_err  = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tmo     <= '0;
      acc     <= '0;
      shadow  <= '0;
      words_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (!ena) begin
      start_q <= 1'b0;
    end else begin
      start_q <= fire;
      if (sof_acc) begin
        shadow[(BPW-1)*IN_W +: IN_W] <= in_data;
        acc   <= in_data;
        cnt   <= CW'(1);
        tmo   <= '0;
        err_q <= 1'b0;
      end else if (data_acc) begin
        // chunk p lands in word p/BPW, most significant chunk first
        for (int unsigned p = 0; p < TOTAL; p++) begin
          if (cnt == CW'(p))
            shadow[(p/BPW)*WORD_W + (BPW-1-(p%BPW))*IN_W +: IN_W] <= in_data;
        end
        acc <= acc ^ in_data;
        cnt <= cnt + CW'(1);
        tmo <= '0;
      end else if (tmo_inc) begin
        tmo <= tmo + TW'(1);
      end
      if (chk_good) words_q <= shadow;
      if (chk_bad || tmo_hit) err_q <= 1'b1;
      if (chk_good || chk_bad || tmo_hit) begin
        cnt <= '0;
        tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_param_stream_loader.sv
// Directed bench for param_stream_loader: default-width instance with TIMEOUT=4
// plus a 3x16-bit / 4-bit-chunk instance for packing generality.
module tb_param_stream_loader;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [7:0]  in_data;
  logic        in_valid, in_sof, core_busy;
  logic        in_ready, start_calc, busy, frame_err;
  logic [63:0] words;

  logic [3:0]  b_data;
  logic        b_valid, b_sof;
  logic        b_ready, b_start, b_busy, b_err;
  logic [47:0] b_words;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_stream_loader #(.NWORDS(2), .WORD_W(32), .IN_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .core_busy(core_busy), .in_ready(in_ready), .words(words),
    .start_calc(start_calc), .busy(busy), .frame_err(frame_err)
  );

  param_stream_loader #(.NWORDS(3), .WORD_W(16), .IN_W(4), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .in_data(b_data), .in_valid(b_valid),
    .in_sof(b_sof), .core_busy(1'b0), .in_ready(b_ready), .words(b_words),
    .start_calc(b_start), .busy(b_busy), .frame_err(b_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chunk(input logic [7:0] d, input logic sof);
    in_data  = d;
    in_valid = 1'b1;
    in_sof   = sof;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // data is listed first-chunk-first from the MSB down
  task automatic send_frame(input logic [63:0] data, input logic [7:0] cs);
    for (int i = 0; i < 8; i++) chunk(data[63-8*i -: 8], i == 0);
    chunk(cs, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ena = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
    core_busy = 1'b0; b_data = '0; b_valid = 1'b0; b_sof = 1'b0;
    tick();
    do_reset();
    check_eq("rst_words", words, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_ready", {63'h0, in_ready}, 64'h1);
    check_eq("rst_err", {63'h0, frame_err}, 64'h0);

    // 1: good frame
    send_frame(64'h12345678_9ABCDEF0, 8'h00);
    check_eq("t1_words", words, 64'h9ABCDEF0_12345678);
    check_eq("t1_arm_busy", {63'h0, busy}, 64'h1);
    check_eq("t1_no_early_start", {63'h0, start_calc}, 64'h0);
    tick();
    check_eq("t1_start", {63'h0, start_calc}, 64'h1);
    check_eq("t1_idle", {63'h0, busy}, 64'h0);
    tick();
    check_eq("t1_start_single", {63'h0, start_calc}, 64'h0);
    check_eq("t1_err", {63'h0, frame_err}, 64'h0);

    // 2: bad checksum
    do_reset();
    send_frame(64'h12345678_9ABCDEF0, 8'h01);
    check_eq("t2_err", {63'h0, frame_err}, 64'h1);
    check_eq("t2_words", words, 64'h0);
    check_eq("t2_idle", {63'h0, busy}, 64'h0);
    tick();
    check_eq("t2_no_start", {63'h0, start_calc}, 64'h0);
    chunk(8'h12, 1'b1);
    check_eq("t2_sof_clears_err", {63'h0, frame_err}, 64'h0);

    // 3: backpressure
    do_reset();
    core_busy = 1'b1;
    send_frame(64'h12345678_9ABCDEF0, 8'h00);
    check_eq("t3_words", words, 64'h9ABCDEF0_12345678);
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_ready_low", {63'h0, in_ready}, 64'h0);
      check_eq("t3_no_start", {63'h0, start_calc}, 64'h0);
      tick();
    end
    core_busy = 1'b0;
    tick();
    check_eq("t3_start", {63'h0, start_calc}, 64'h1);
    tick();
    check_eq("t3_start_single", {63'h0, start_calc}, 64'h0);

    // 4: timeout after sof + 3 chunks
    do_reset();
    chunk(8'h12, 1'b1); chunk(8'h34, 1'b0); chunk(8'h56, 1'b0); chunk(8'h78, 1'b0);
    tick(); tick(); tick();
    check_eq("t4_still_load", {63'h0, busy}, 64'h1);
    check_eq("t4_no_err_yet", {63'h0, frame_err}, 64'h0);
    tick();
    check_eq("t4_timeout_idle", {63'h0, busy}, 64'h0);
    check_eq("t4_timeout_err", {63'h0, frame_err}, 64'h1);
    send_frame(64'h12345678_9ABCDEF0, 8'h00);
    check_eq("t4_recover_words", words, 64'h9ABCDEF0_12345678);
    check_eq("t4_recover_err", {63'h0, frame_err}, 64'h0);
    tick();
    check_eq("t4_recover_start", {63'h0, start_calc}, 64'h1);

    // 5a: restart mid-frame
    do_reset();
    chunk(8'h12, 1'b1); chunk(8'h34, 1'b0); chunk(8'h56, 1'b0);
    send_frame(64'hA1B2C3D4_E5F60718, 8'h08);
    check_eq("t5_restart_words", words, 64'hE5F60718_A1B2C3D4);
    tick();
    check_eq("t5_restart_start", {63'h0, start_calc}, 64'h1);

    // 5b: ena low mid-frame
    chunk(8'h12, 1'b1); chunk(8'h34, 1'b0); chunk(8'h56, 1'b0);
    ena = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; ena = 1'b1;
    check_eq("t5_ena_no_timeout", {63'h0, frame_err}, 64'h0);
    check_eq("t5_ena_busy", {63'h0, busy}, 64'h1);
    chunk(8'h78, 1'b0); chunk(8'h9A, 1'b0); chunk(8'hBC, 1'b0);
    chunk(8'hDE, 1'b0); chunk(8'hF0, 1'b0); chunk(8'h00, 1'b0);
    check_eq("t5_ena_words", words, 64'h9ABCDEF0_12345678);
    tick();
    check_eq("t5_ena_start", {63'h0, start_calc}, 64'h1);

    // 6a: reset while armed
    do_reset();
    core_busy = 1'b1;
    send_frame(64'h12345678_9ABCDEF0, 8'h00);
    check_eq("t6_arm_words", words, 64'h9ABCDEF0_12345678);
    core_busy = 1'b0;
    do_reset();
    check_eq("t6_rst_words", words, 64'h0);
    check_eq("t6_rst_busy", {63'h0, busy}, 64'h0);
    check_eq("t6_rst_no_start", {63'h0, start_calc}, 64'h0);
    tick();
    check_eq("t6_rst_no_start2", {63'h0, start_calc}, 64'h0);

    // 6b: 3 x 16-bit words from nibbles 1..C, checksum C
    for (int i = 1; i <= 13; i++) begin
      b_data  = (i == 13) ? 4'hC : 4'(i);
      b_valid = 1'b1;
      b_sof   = (i == 1);
      tick();
    end
    b_valid = 1'b0; b_sof = 1'b0;
    check_eq("t6_gen_words", {16'h0, b_words}, 64'h9ABC_5678_1234);
    check_eq("t6_gen_err", {63'h0, b_err}, 64'h0);
    tick();
    check_eq("t6_gen_start", {63'h0, b_start}, 64'h1);
    tick();
    check_eq("t6_gen_start_single", {63'h0, b_start}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_stream_loader.md
Name: param_stream_loader

Overview:
- Parametrised successor to the two-word pin parameter loader.
- Assembles NWORDS words of WORD_W bits from a chunk-serial input stream of IN_W-bit chunks.
- Validates each frame with an XOR checksum chunk and a gap timeout.
- Commits good frames atomically to the word outputs, then issues a single start pulse to the compute core once the core is not busy.

Parameters:
- NWORDS, 2, number of words per frame (>=1)
- WORD_W, 32, bits per word; must be an integer multiple of IN_W
- IN_W, 8, bits per input chunk
- TIMEOUT, 255, maximum idle cycles between chunks inside a frame (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- ena  in  1  block enable; when low, all state, counters and outputs hold
- in_data  in  IN_W  chunk data
- in_valid  in  1  chunk strobe; one chunk is accepted per cycle with in_valid=1 and in_ready=1
- in_sof  in  1  qualifies in_valid: this chunk is chunk 0 of a new frame
- core_busy  in  1  downstream core busy; start_calc is withheld while high
- in_ready  out  1  state is IDLE or LOAD
- words  out  NWORDS*WORD_W  committed words; word k occupies bits [k*WORD_W +: WORD_W]
- start_calc  out  1  one-cycle pulse after a good frame is committed
- busy  out  1  state is not IDLE
- frame_err  out  1  sticky error flag; cleared by the next accepted in_sof

Behaviour:
- Derived constants:
  - BPW = WORD_W/IN_W
  - TOTAL = NWORDS*BPW data chunks, followed by 1 checksum chunk
- Frame order and packing:
  - Word 0 is sent first.
  - Within each word, the most significant chunk is sent first.
- Reset (rst=1 at an edge):
  - state=IDLE; words=0; start_calc=0; frame_err=0.
  - Chunk counter, timeout counter, checksum accumulator and shadow registers are all cleared.
  - Reset mid-frame discards the partial frame; no start pulse is issued.
- ena=0: no chunk is accepted, counters freeze, no state transitions occur. start_calc is driven 0.
- Data path:
  - Incoming chunks go into shadow registers only.
  - words changes only on commit, so it is never partially updated.
- IDLE:
  - in_valid & in_sof: store chunk 0, acc=in_data, cnt=1, clear frame_err, go to LOAD.
  - in_valid without in_sof: chunk is dropped.
- LOAD:
  - in_valid & in_sof: restart the frame. The chunk becomes chunk 0 (acc=in_data, cnt=1). The partial frame is discarded and frame_err is cleared.
  - in_valid, cnt<TOTAL: store the chunk at position cnt, acc ^= in_data, cnt++, clear the timeout counter.
  - in_valid, cnt==TOTAL: this is the checksum chunk.
    - If in_data==acc: copy shadow to words at this edge and go to ARM.
    - Otherwise: set frame_err=1, leave words unchanged, go to IDLE.
  - No in_valid: timeout counter increments. When it reaches TIMEOUT: set frame_err=1 and go to IDLE.
- ARM:
  - in_ready=0; all input chunks are ignored.
  - At an edge with core_busy=0: start_calc<=1 for exactly one cycle, go to IDLE.
  - While core_busy=1: hold in ARM indefinitely.
- Latency: checksum accepted at edge E → words valid after E → start_calc high during the cycle after edge E+1, provided core_busy=0 at E+1.
- Simultaneous events:
  - rst overrides everything.
  - ena=0 overrides in_valid and core_busy.
  - in_sof with cnt==TOTAL is treated as a restart, not as a checksum.
- Width rules:
  - Counters are sized with clog2(TOTAL+1) and clog2(TIMEOUT+1) bits.
  - Counters never wrap, because every terminal count forces a state change.

Test Plan (NWORDS=2, WORD_W=32, IN_W=8, TIMEOUT=4 unless noted):
1. Good frame: chunks 12(sof) 34 56 78 9A BC DE F0, checksum 00, core_busy=0 → words=0x9ABCDEF0_12345678; start_calc is a single pulse 2 edges after the checksum; frame_err=0; busy returns low.
2. Bad checksum: same data, checksum 01 → frame_err=1, words stay 0, no start_calc; next sof clears frame_err.
3. Backpressure: good frame with core_busy=1 held for 10 cycles → words commit immediately; in_ready=0 and no start_calc while busy; pulse occurs one edge after core_busy falls.
4. Timeout: sof plus 3 chunks, then 4 idle cycles → frame_err=1, state IDLE; a following complete good frame commits normally.
5. Restart and ena: new sof mid-frame → old chunks discarded, new frame commits correctly. ena=0 for 5 cycles mid-frame → no timeout and no chunk accepted; the frame resumes and completes when ena returns high.
6. Reset mid-ARM and generality: assert rst while in ARM → no start_calc, words=0. Repeat scenario 1 with NWORDS=3, WORD_W=16, IN_W=4 (12 data nibbles + 1 checksum nibble) → correct packing and pulse.
